// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential partial-product multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/pp_row_gen.sv
// Partial-product row generator: gates a whole vector by a single multiplier bit.
module pp_row_gen #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_vec,
  input  logic         i_bit,
  output logic [W-1:0] o_row
);

  assign o_row = i_vec & {W{i_bit}};

endmodule

// File: rtl/pp_shift_accumulator.sv
// Shift-and-add multiplier consuming one partial-product row per cycle.
// Optional PP_EARLY_EXIT_EN ends the run once no set multiplier bits remain.
module pp_shift_accumulator
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                A,
  input  logic [WIDTH-1:0]                B,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [prod_width(WIDTH)-1:0]    product,
  output logic                            busy
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t          r_state;
  state_t          w_next_state;
  logic [PW-1:0]   r_a_sh;
  logic [PW-1:0]   r_acc;
  logic [WIDTH-1:0] r_b_sh;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   w_row;
  logic            w_accept;
  logic            w_last;

  pp_row_gen #(.W(PW)) u_row_gen (
    .i_vec (r_a_sh),
    .i_bit (r_b_sh[0]),
    .o_row (w_row)
  );

  assign w_accept = in_valid && (r_state == IDLE);

`ifdef PP_EARLY_EXIT_EN
  // Remaining multiplier bits above the current one are all zero: this row is the last useful one.
  assign w_last = (r_cnt == CW'(WIDTH - 1)) || ((r_b_sh >> 1) == '0);
`else
  assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: default assignment first so no path through the case leaves the signal unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state == RUN);
  end

  // NOTE: all datapath registers reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a_sh <= {{WIDTH{1'b0}}, A};
            r_b_sh <= B;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        RUN: begin
          r_acc  <= r_acc + w_row;
          r_a_sh <= r_a_sh << 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign product = r_acc;

endmodule

// File: tb/tb_pp_shift_accumulator.sv
// Scoreboard bench for pp_shift_accumulator: driver pushes expected products, monitor checks them.
module tb_pp_shift_accumulator;

  localparam int WIDTH = 16;
  localparam int PW    = 2 * WIDTH;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    product;
  logic             busy;

  typedef struct {
    logic [PW-1:0] prod;
    int            acc_cyc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   inflight = 0;
  bit   prev_v   = 0;

  pp_shift_accumulator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [WIDTH-1:0] b);
`ifdef PP_EARLY_EXIT_EN
    int hi = 0;
    for (int i = 0; i < WIDTH; i++) if (b[i]) hi = i;
    return hi + 1;
`else
    return WIDTH;
`endif
  endfunction

  // Called just after a rising edge; returns after the accept edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [PW-1:0] exp_prod, output int acc_cyc);
    bit got = 0;
    exp_t e;
    acc_cyc  = -1;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      check("accept_timeout", 0, 1);
    end else begin
      acc_cyc   = cyc;
      e.prod    = exp_prod;
      e.acc_cyc = cyc;
      e.lat     = lat_of(b);
      sb.push_back(e);
      inflight  = 1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 0);
      sb.delete();
      inflight = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented product against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 0;
      end else begin
        if (inflight) begin
          check("in_ready_low_inflight", 64'(in_ready), 0);
          if (!out_valid) check("busy_in_run", 64'(busy), 1);
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 0);
          end else begin
            if (!prev_v) check("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
            check("product", 64'(product), 64'(sb[0].prod));
            if (out_ready) begin
              void'(sb.pop_front());
              inflight = 0;
            end
          end
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    int c1, c2, c_dummy;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_product", 64'(product), 0);
    check("rst_busy", 64'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic multiply with fixed-latency run.
    issue(16'd3, 16'd5, 32'h0000_000F, c_dummy);
    drain();

    // Full-scale operands, consumer stalls 5 cycles in DONE.
    out_ready = 1'b0;
    issue(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, c_dummy);
    for (int n = 0; n < 100 && !out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    check("done_reached", 64'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a_in     = 16'h0005;
      b_in     = 16'h0005;
      @(negedge clk);
      check("in_ready_low_done", 64'(in_ready), 0);
      check("hold_product", 64'(product), 64'h0000_0000_FFFE_0001);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a run discards the operation.
    issue(16'h1111, 16'h1111, 32'h0123_4321, c_dummy);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    inflight = 0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_in_ready", 64'(in_ready), 1);
    check("midrst_product", 64'(product), 0);
    check("midrst_busy", 64'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(16'd2, 16'd7, 32'h0000_000E, c_dummy);
    drain();

    // Back-to-back operations: initiation interval.
    issue(16'h0001, 16'h8000, 32'h0000_8000, c1);
    issue(16'h1234, 16'h0000, 32'h0000_0000, c2);
    check("init_interval", 64'(c2 - c1), 64'(lat_of(16'h8000) + 2));
    drain();

    // Sparse multipliers (latency depends on early-exit build option).
    issue(16'hABCD, 16'h0001, 32'h0000_ABCD, c_dummy);
    drain();
    issue(16'h1234, 16'h0010, 32'h0001_2340, c_dummy);
    drain();
    issue(16'h0007, 16'h0000, 32'h0000_0000, c_dummy);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
